// File: rtl/mem_interface_ctrl.sv
// Memory-side sequencer for the MDR stage: turns Read/Write strobes into a req/ack
// memory transaction, captures read data for the MDR and bounds each wait with a timeout.
module mem_interface_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] MAR_addr,
    input  logic [DATA_W-1:0] MDR_data_out,
    output logic [DATA_W-1:0] MDR_data_in,
    output logic              MDR_load,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_mdr_data;
    logic                r_mdr_load;
    logic                r_req;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_busy;
    logic                r_done;
    logic                r_timeout_err;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_mdr_data    <= '0;
            r_mdr_load    <= 1'b0;
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_mdr_load <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Read || Write) begin
                        r_addr        <= MAR_addr;
                        r_wdata       <= MDR_data_out;
                        r_we          <= Write & ~Read;
                        r_timeout_err <= 1'b0;
                        r_cnt         <= '0;
                        r_req         <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        r_req      <= 1'b0;
                        r_done     <= 1'b1;
                        r_mdr_load <= ~r_we;
                        if (!r_we) begin
                            r_mdr_data <= mem_rdata;
                        end
                        r_state    <= S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        // Counter started at 0 on accept, so this aborts after TIMEOUT wait cycles
                        r_req         <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_state       <= S_ABORT;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE, S_ABORT: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign MDR_data_in = r_mdr_data;
    assign MDR_load    = r_mdr_load;
    assign mem_req     = r_req;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_interface_ctrl.sv
// Directed bench for mem_interface_ctrl: a table of single transfers plus hand-written
// sequences for reset, timeout, ignored strobes and back-to-back reads.
module tb_mem_interface_ctrl;

    logic        clock = 1'b0;
    logic        clear;
    logic        Read, Write;
    logic [8:0]  MAR_addr;
    logic [31:0] MDR_data_out;
    logic [31:0] MDR_data_in;
    logic        MDR_load;
    logic        mem_req, mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy, done, timeout_err;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    mem_interface_ctrl #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(15)) dut (
        .clock(clock), .clear(clear), .Read(Read), .Write(Write),
        .MAR_addr(MAR_addr), .MDR_data_out(MDR_data_out), .MDR_data_in(MDR_data_in),
        .MDR_load(MDR_load), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (done === 1'b1) done_cnt++;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [8:0]  addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic        exp_we;
        logic [31:0] exp_mdr;
        logic        exp_load;
    } vec_t;

    vec_t vecs[5];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        Read = v.rd; Write = v.wr; MAR_addr = v.addr; MDR_data_out = v.wdata;
        tick;
        Read = 1'b0; Write = 1'b0; MAR_addr = 9'h000; MDR_data_out = 32'h0;
        chk("acc_req",   {31'd0, mem_req}, 32'd1);
        chk("acc_busy",  {31'd0, busy}, 32'd1);
        chk("acc_we",    {31'd0, mem_we}, {31'd0, v.exp_we});
        chk("acc_addr",  {23'd0, mem_addr}, {23'd0, v.addr});
        if (v.exp_we) chk("acc_wdata", mem_wdata, v.wdata);
        for (int i = 0; i < v.delay; i++) begin
            tick;
            chk("wait_req",  {31'd0, mem_req}, 32'd1);
            chk("wait_addr", {23'd0, mem_addr}, {23'd0, v.addr});
        end
        mem_ack = 1'b1; mem_rdata = v.rdata;
        tick;
        mem_ack = 1'b0; mem_rdata = 32'hFFFF_0000;
        chk("done",      {31'd0, done}, 32'd1);
        chk("done_load", {31'd0, MDR_load}, {31'd0, v.exp_load});
        chk("done_mdr",  MDR_data_in, v.exp_mdr);
        chk("done_req",  {31'd0, mem_req}, 32'd0);
        tick;
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_load", {31'd0, MDR_load}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        $display("vec %0d: rd=%0d wr=%0d addr=%h mdr=%h", idx, v.rd, v.wr, v.addr, MDR_data_in);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        vecs[0] = '{1'b1, 1'b0, 9'h04A, 32'h0000_0000, 2, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 9'h1FF, 32'hA5A5_A5A5, 0, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 9'h055, 32'h1111_1111, 1, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 9'h0C3, 32'h3C3C_3C3C, 3, 32'h7777_7777, 1'b1, 32'h0BAD_F00D, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 9'h100, 32'h5555_5555, 0, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001, 1'b1};

        clear = 1'b0; Read = 1'b0; Write = 1'b0; MAR_addr = 9'h0; MDR_data_out = 32'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        tick; tick;
        chk("rst_req",   {31'd0, mem_req}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_load",  {31'd0, MDR_load}, 32'd0);
        chk("rst_terr",  {31'd0, timeout_err}, 32'd0);
        chk("rst_we",    {31'd0, mem_we}, 32'd0);
        chk("rst_mdr",   MDR_data_in, 32'd0);
        chk("rst_addr",  {23'd0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        $display("reset: outputs checked");
        clear = 1'b1;
        tick;

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Timeout: 15 WAIT cycles without ack
        Read = 1'b1; MAR_addr = 9'h033;
        tick;
        Read = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 14; i++) begin
            tick;
            chk("to_req_held", {31'd0, mem_req}, 32'd1);
        end
        tick;
        chk("to_req_drop", {31'd0, mem_req}, 32'd0);
        chk("to_terr",     {31'd0, timeout_err}, 32'd1);
        chk("to_busy",     {31'd0, busy}, 32'd1);
        tick;
        chk("to_idle",     {31'd0, busy}, 32'd0);
        chk("to_terr_st",  {31'd0, timeout_err}, 32'd1);
        chk("to_mdr",      MDR_data_in, 32'hCAFE_0001);
        chk("to_nodone",   done_cnt, d0);
        $display("timeout: terr=%0d req=%0d", timeout_err, mem_req);
        Read = 1'b1; MAR_addr = 9'h034;
        tick;
        Read = 1'b0;
        chk("to_clr_on_acc", {31'd0, timeout_err}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0042;
        tick;
        mem_ack = 1'b0;
        chk("to_next_mdr", MDR_data_in, 32'h0000_0042);
        tick;
        $display("after timeout read: mdr=%h terr=%0d", MDR_data_in, timeout_err);

        // Strobes during WAIT are ignored
        d0 = done_cnt;
        Read = 1'b1; MAR_addr = 9'h0EE;
        tick;
        Read = 1'b1; Write = 1'b1; MAR_addr = 9'h011;
        tick; tick;
        Read = 1'b0; Write = 1'b0;
        chk("ign_addr", {23'd0, mem_addr}, 32'h0EE);
        chk("ign_we",   {31'd0, mem_we}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0099;
        tick;
        mem_ack = 1'b0;
        tick; tick; tick;
        chk("ign_busy",  {31'd0, busy}, 32'd0);
        chk("ign_count", done_cnt, d0 + 1);
        $display("ignore: dones=%0d", done_cnt - d0);

        // Asynchronous reset in the middle of WAIT
        Read = 1'b1; MAR_addr = 9'h077;
        tick;
        Read = 1'b0;
        chk("mid_req_pre", {31'd0, mem_req}, 32'd1);
        #2 clear = 1'b0;
        #1;
        chk("mid_req",  {31'd0, mem_req}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_done", {31'd0, done}, 32'd0);
        chk("mid_load", {31'd0, MDR_load}, 32'd0);
        tick;
        clear = 1'b1;
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        chk("mid_idle", {31'd0, busy}, 32'd0);
        chk("mid_nodone", {31'd0, done}, 32'd0);
        $display("reset mid-WAIT: req=%0d busy=%0d", mem_req, busy);

        // Back-to-back reads with Read held high
        Read = 1'b1; MAR_addr = 9'h010;
        tick;
        mem_ack = 1'b1; mem_rdata = 32'hFEDC_BA98;
        tick;
        mem_ack = 1'b0; mem_rdata = 32'h8765_4321;
        chk("b2b_done1", {31'd0, done}, 32'd1);
        chk("b2b_mdr1",  MDR_data_in, 32'hFEDC_BA98);
        tick;
        chk("b2b_gap",   {31'd0, mem_req}, 32'd0);
        tick;
        chk("b2b_req2",  {31'd0, mem_req}, 32'd1);
        Read = 1'b0;
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        chk("b2b_done2", {31'd0, done}, 32'd1);
        chk("b2b_mdr2",  MDR_data_in, 32'h8765_4321);
        tick;
        $display("back-to-back: mdr=%h", MDR_data_in);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
